imm_gen_pipe: RTL
=================

Name: imm_gen_pipe

Overview:
Parametrised, pipelined immediate generator for the RV32/RV64 decode stage. Extracts and sign- or zero-extends the immediate for I, S, B, J, U, CSR-zimm and shift-amount formats. Results are registered into a 2-entry elastic buffer with valid/ready handshakes on both sides, so decode and execute can stall independently. A pass-through tag (e.g. rd/ROB index) travels with each immediate.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64
- TAG_W, 5, width of the side-band tag carried with each entry
- ENABLE_ZIMM, 1, 1 enables mode 5 (CSR zimm); 0 makes mode 5 illegal

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous pipeline flush; discards buffer contents
- in_valid  in  1  upstream has an instruction
- in_ready  out  1  block can accept this cycle
- in_instr  in  32  raw instruction word
- in_mode  in  3  format: 0=I 1=S 2=B 3=J 4=U 5=Z 6=SH 7=reserved
- in_tag  in  TAG_W  side-band tag
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts the head entry
- out_imm  out  XLEN  extended immediate
- out_tag  out  TAG_W  tag of the head entry
- out_err  out  1  head entry had an illegal mode

Behaviour:
- Reset (rst_n low, asynchronous):
  - count=0; out_valid=0; out_imm=0; out_tag=0; out_err=0; both storage slots cleared to 0.
  - Inputs are ignored while rst_n is low.
- Immediate formation (combinational on the input side, registered on push). s = in_instr[31]; every result is sign-extended from s to XLEN unless stated otherwise.
  - I: instr[31:20]
  - S: {instr[31:25], instr[11:7]}
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - U: {instr[31:12], 12'b0}; for XLEN=64, bits 63:32 are copies of bit 31.
  - Z: zero-extend instr[19:15]; if ENABLE_ZIMM=0, treat as illegal.
  - SH: zero-extend instr[24:20] when XLEN=32; zero-extend instr[25:20] when XLEN=64.
  - Mode 7, or a disabled Z: imm=0, err=1. Otherwise err=0.
- Buffer: 2-entry FIFO (head + skid), count in 0..2.
  - in_ready = (count<2) combinational from count. Push when in_valid && in_ready.
  - out_valid = (count>0). out_imm, out_tag and out_err always show the head entry; they hold their previous value when count=0.
  - Pop when out_valid && out_ready.
  - Latency: an entry pushed in cycle N is visible at the output in cycle N+1 when the buffer was empty. Throughput is 1 per cycle with no backpressure.
  - Push and pop in the same cycle: count unchanged; FIFO order is preserved.
  - count=2: in_ready=0; upstream must hold its data stable (standard valid/ready).
  - Output stability: while out_valid && !out_ready, out_imm, out_tag and out_err must not change.
- Flush: on a clk edge with flush=1, count goes to 0 and any push or pop that cycle is cancelled. out_valid=0 from the next cycle. Flush has priority over push and pop.
- Reset mid-operation: all entries are lost immediately; no partial push survives.

Test Plan:
1. XLEN=32, I mode, instr 0xFFF00093, out_ready=1 -> one cycle later: out_valid=1, out_imm=0xFFFFFFFF, out_err=0, out_tag equal to the input tag.
2. B mode, instr 0xFE000EE3 -> out_imm=0xFFFFFFFC. J mode, instr 0x0080006F -> out_imm=0x00000008.
3. XLEN=64, U mode, instr 0x80000037 -> out_imm=0xFFFFFFFF80000000. SH mode, instr 0x03F0D093 -> out_imm=0x3F.
4. Backpressure: out_ready=0, offer tags 1,2,3 back-to-back -> 1 and 2 accepted, in_ready=0 while 3 is held. Raise out_ready -> tags pop in order 1,2,3 with one per cycle, and the held output stays stable throughout the stall.
5. count=2, then flush=1 together with in_valid=1 -> next cycle out_valid=0 and count=0; the offered entry is not stored.
6. Mode 7 -> out_imm=0, out_err=1. Drive rst_n low with count=2 -> out_valid=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : imm_gen_pipe
//  Description : RV32/RV64 decode-stage immediate generator. Forms the
//                I/S/B/J/U/zimm/shamt immediate from a raw instruction and
//                queues it, with its side-band tag, in a 2-entry elastic
//                buffer that has valid/ready handshakes on both sides.
//  Revision    : 1.0  initial release
// ============================================================================
module imm_gen_pipe #(
   parameter int XLEN        = 32,
   parameter int TAG_W       = 5,
   parameter bit ENABLE_ZIMM = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [2:0]       in_mode,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_err
);

   localparam logic [2:0] MODE_I  = 3'd0;
   localparam logic [2:0] MODE_S  = 3'd1;
   localparam logic [2:0] MODE_B  = 3'd2;
   localparam logic [2:0] MODE_J  = 3'd3;
   localparam logic [2:0] MODE_U  = 3'd4;
   localparam logic [2:0] MODE_Z  = 3'd5;
   localparam logic [2:0] MODE_SH = 3'd6;

   // Stored entry layout: {err, tag, imm}
   localparam int ENTRY_W = XLEN + TAG_W + 1;

   logic               sign_bit;
   logic [5:0]         shamt;
   logic [63:0]        wide_imm;
   logic               new_err;
   logic [ENTRY_W-1:0] new_entry;
   logic               push;
   logic               pop;
   logic               unused_bits;

   logic [1:0]         count_q, count_d;
   logic [ENTRY_W-1:0] slot0_q, slot0_d;
   logic [ENTRY_W-1:0] slot1_q, slot1_d;

   assign sign_bit = in_instr[31];

   // RV64 shift amounts carry one extra bit (instr[25])
   generate
      if (XLEN == 64) begin : g_shamt64
         assign shamt = in_instr[25:20];
      end else begin : g_shamt32
         assign shamt = {1'b0, in_instr[24:20]};
      end
   endgenerate

   // Immediate formed at full 64-bit width, then truncated to XLEN below
   always_comb begin
      wide_imm = '0;
      new_err  = 1'b0;
      case (in_mode)
         MODE_I:  wide_imm = {{52{sign_bit}}, in_instr[31:20]};
         MODE_S:  wide_imm = {{52{sign_bit}}, in_instr[31:25], in_instr[11:7]};
         MODE_B:  wide_imm = {{51{sign_bit}}, in_instr[31], in_instr[7],
                              in_instr[30:25], in_instr[11:8], 1'b0};
         MODE_J:  wide_imm = {{43{sign_bit}}, in_instr[31], in_instr[19:12],
                              in_instr[20], in_instr[30:21], 1'b0};
         MODE_U:  wide_imm = {{32{sign_bit}}, in_instr[31:12], 12'b0};
         MODE_Z: begin
            if (ENABLE_ZIMM) begin
               wide_imm = {59'b0, in_instr[19:15]};
            end else begin
               new_err = 1'b1;
            end
         end
         MODE_SH: wide_imm = {58'b0, shamt};
         default: new_err = 1'b1;
      endcase
   end

   assign new_entry   = {new_err, in_tag, wide_imm[XLEN-1:0]};
   assign unused_bits = ^{in_instr[6:0], wide_imm[63:32]};

   assign in_ready  = (count_q != 2'd2);
   assign out_valid = (count_q != 2'd0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // Head always sits in slot0; slot1 is the skid entry behind it
   assign out_imm = slot0_q[XLEN-1:0];
   assign out_tag = slot0_q[XLEN +: TAG_W];
   assign out_err = slot0_q[ENTRY_W-1];

   // Buffer next state: flush wins, otherwise shift/append in FIFO order
   always_comb begin
      count_d = count_q;
      slot0_d = slot0_q;
      slot1_d = slot1_q;
      if (flush) begin
         count_d = 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count_q == 2'd0) begin
                  slot0_d = new_entry;
               end else begin
                  slot1_d = new_entry;
               end
               count_d = count_q + 2'd1;
            end
            2'b01: begin
               if (count_q == 2'd2) begin
                  slot0_d = slot1_q;
               end
               count_d = count_q - 2'd1;
            end
            2'b11: begin
               // Only reachable with count 1: head leaves, new entry becomes head
               slot0_d = new_entry;
            end
            default: ;
         endcase
      end
   end

   // Buffer state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= 2'd0;
         slot0_q <= '0;
         slot1_q <= '0;
      end else begin
         count_q <= count_d;
         slot0_q <= slot0_d;
         slot1_q <= slot1_d;
      end
   end

endmodule
`default_nettype wire
